// File: rtl/booth_seq_ctrl_if.sv
// Handshake/data bundle for booth_seq_ctrl.
//   start : request a multiply (requester -> multiplier)
//   a, m  : signed multiplier / multiplicand, N bits two's complement
//   busy  : operation in progress (multiplier -> requester)
//   done  : one-cycle pulse when p is updated
//   p     : 2N-bit signed product, held until the next done
// All vectors are plain logic; the multiplier treats them as two's complement.
interface booth_seq_ctrl_if #(
  parameter int unsigned N = 4
) ();
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   m;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  modport master (
    output start, a, m,
    input  busy, done, p
  );

  modport slave (
    input  start, a, m,
    output busy, done, p
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier. One recode/add/shift step per clock reuses a single
// N+1-bit adder for all N iterations.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (aborts any operation, clears p)
//   bus : booth_seq_ctrl_if slave modport (start/a/m in, busy/done/p out)
// Timing: start accepted at edge t in IDLE; RUN for N cycles, DONE for one cycle; p and done
// are registered on the edge leaving DONE, so done is visible in the cycle after edge t+N+1,
// which is also an IDLE cycle able to accept the next start.
module booth_seq_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic            clk,
  input  logic            rst,
  booth_seq_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [N:0]      acc_q, acc_d;   // extra bit keeps -mreg exact for mreg = -2^(N-1)
  logic [N-1:0]    q_q, q_d;
  logic            q0_q, q0_d;
  logic [N-1:0]    mreg_q, mreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]  p_q, p_d;
  logic            done_q, done_d;

  logic [N:0]      addend;
  logic [N:0]      sum;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q0_d    = q0_q;
    mreg_d  = mreg_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
    addend  = {mreg_q[N-1], mreg_q};
    sum     = acc_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          q_d     = bus.a;
          mreg_d  = bus.m;
          acc_d   = '0;
          q0_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        case ({q_q[0], q0_q})
          2'b10:   sum = acc_q - addend;
          2'b01:   sum = acc_q + addend;
          default: sum = acc_q;
        endcase
        // Arithmetic shift right of {acc, q, q0}; acc MSB is replicated.
        acc_d = {sum[N], sum[N:1]};
        q_d   = {sum[0], q_q[N-1:1]};
        q0_d  = q_q[0];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // acc[N] is only a sign copy of acc[N-1] by now.
        p_d     = {acc_q[N-1:0], q_q};
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      q_q     <= '0;
      q0_q    <= 1'b0;
      mreg_q  <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q0_q    <= q0_d;
      mreg_q  <= mreg_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  booth_seq_ctrl_if #(.N(4)) b4 ();
  booth_seq_ctrl_if #(.N(8)) b8 ();

  booth_seq_ctrl #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  booth_seq_ctrl #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One N=4 multiply; checks product, latency (N+2 counting the accepting cycle) and
  // optionally the busy length (N+1 cycles).
  task automatic run4(input int ai, input int mi, input string tag, input bit chk_busy);
    int cyc;
    int busy_cnt;
    logic [7:0] e;
    e = 8'(ai * mi);
    b4.a = 4'(ai);
    b4.m = 4'(mi);
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    cyc = 1;
    busy_cnt = b4.busy ? 1 : 0;
    while (!b4.done && cyc < 20) begin
      tick();
      cyc++;
      if (b4.busy) busy_cnt++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'd6);
    check({tag, "_p"}, 64'(b4.p), 64'(e));
    if (chk_busy) check({tag, "_busy"}, 64'(busy_cnt), 64'd5);
  endtask

  task automatic run8(input int ai, input int mi, input string tag);
    int cyc;
    logic [15:0] e;
    e = 16'(ai * mi);
    b8.a = 8'(ai);
    b8.m = 8'(mi);
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    cyc = 1;
    while (!b8.done && cyc < 30) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'd10);
    check({tag, "_p"}, 64'(b8.p), 64'(e));
  endtask

  initial begin
    int ndone;
    int nbusy_lo;
    int last_done;
    b4.start = 1'b0; b4.a = '0; b4.m = '0;
    b8.start = 1'b0; b8.a = '0; b8.m = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 64'(b4.busy), 64'd0);
    check("rst_done", 64'(b4.done), 64'd0);
    check("rst_p", 64'(b4.p), 64'd0);
    check("rst_p8", 64'(b8.p), 64'd0);

    // 1: basic
    run4(3, 2, "t1", 1'b1);
    check("t1_p_abs", 64'(b4.p), 64'h06);
    tick();
    check("t1_done_pulse", 64'(b4.done), 64'd0);
    check("t1_p_hold", 64'(b4.p), 64'h06);

    // 2: corner operands (hand-computed)
    run4(-8, -8, "t2a", 1'b0);
    check("t2a_abs", 64'(b4.p), 64'h40);
    run4(-8, 7, "t2b", 1'b0);
    check("t2b_abs", 64'(b4.p), 64'hC8);
    run4(7, -1, "t2c", 1'b0);
    check("t2c_abs", 64'(b4.p), 64'hF9);
    run4(0, -8, "t2d", 1'b0);
    check("t2d_abs", 64'(b4.p), 64'h00);

    // 3: starts during RUN/DONE ignored, operands captured at accept
    b4.a = 4'd5; b4.m = 4'd3; b4.start = 1'b1;
    tick();                              // accepting edge t
    b4.start = 1'b0; b4.a = 4'd1; b4.m = 4'd1;
    tick();                              // t+1
    b4.start = 1'b1;
    tick();                              // t+2, ignored
    b4.a = 4'd2; b4.m = 4'd6;
    tick();                              // t+3
    b4.a = 4'd7;
    tick();                              // t+4, now DONE
    check("t3_busy_done_state", 64'(b4.busy), 64'd1);
    b4.a = 4'd3;
    tick();                              // t+5, start in DONE ignored
    check("t3_done", 64'(b4.done), 64'd1);
    check("t3_p", 64'(b4.p), 64'h0F);
    b4.start = 1'b0;
    ndone = 0; nbusy_lo = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b4.done) ndone++;
      if (!b4.busy) nbusy_lo++;
    end
    check("t3_no_second_done", 64'(ndone), 64'd0);
    check("t3_idle", 64'(nbusy_lo), 64'd10);

    // 4: start held high for 20 cycles
    b4.a = 4'(-3); b4.m = 4'd5; b4.start = 1'b1;
    ndone = 0; nbusy_lo = 0; last_done = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!b4.busy) nbusy_lo++;
      if (b4.done) begin
        ndone++;
        check($sformatf("t4_p_%0d", ndone), 64'(b4.p), 64'hF1);
        check($sformatf("t4_gap_%0d", ndone), 64'(i - last_done), 64'd6);
        check($sformatf("t4_busylo_%0d", ndone), 64'(b4.busy), 64'd0);
        last_done = i;
      end
    end
    check("t4_ndone", 64'(ndone), 64'd3);
    check("t4_nbusy_lo", 64'(nbusy_lo), 64'd3);
    b4.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // 5: reset mid-RUN
    run4(3, 2, "t5pre", 1'b0);
    b4.a = 4'd7; b4.m = 4'd7; b4.start = 1'b1;
    tick();                              // accept, count=0
    b4.start = 1'b0;
    tick(); tick();                      // count=2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 64'(b4.busy), 64'd0);
    check("t5_done", 64'(b4.done), 64'd0);
    check("t5_p", 64'(b4.p), 64'h00);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b4.done) ndone++;
    end
    check("t5_no_done", 64'(ndone), 64'd0);
    run4(-2, 3, "t5post", 1'b1);
    check("t5post_abs", 64'(b4.p), 64'hFA);

    // 6: exhaustive N=4, random N=8 (plus N=8 extremes)
    for (int ai = -8; ai < 8; ai++) begin
      for (int mi = -8; mi < 8; mi++) begin
        run4(ai, mi, $sformatf("t6_%0d_%0d", ai, mi), 1'b0);
      end
    end
    run8(-128, -128, "t6w_min_min");
    check("t6w_min_min_abs", 64'(b8.p), 64'h4000);
    run8(127, -128, "t6w_max_min");
    for (int k = 0; k < 1500; k++) begin
      int ai;
      int mi;
      ai = int'($urandom_range(255)) - 128;
      mi = int'($urandom_range(255)) - 128;
      run8(ai, mi, $sformatf("t6w_%0d_%0d", ai, mi));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
